// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, datapath mux codes,
// controller states and the decoded opcode class.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC_R = 4'd3,
    ST_WB_R   = 4'd4,
    ST_EXEC_I = 4'd5,
    ST_WB_I   = 4'd6,
    ST_MEMADR = 4'd7,
    ST_MEMRD  = 4'd8,
    ST_MEMWB  = 4'd9,
    ST_MEMWR  = 4'd10,
    ST_BRANCH = 4'd11,
    ST_JUMP   = 4'd12,
    ST_TRAP   = 4'd13
  } state_t;

  typedef struct packed {
    logic       is_r;
    logic       is_mem;
    logic       is_lw;
    logic       is_beq;
    logic       is_imm;
    logic [2:0] imm_aluop;
    logic       is_j;
    logic       illegal;
  } op_class_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath/memory bundle: opcode, ALU zero, memory handshake and all control strobes.
interface multicycle_control_fsm_if;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       MemRead;
  logic       MemToWrite;
  logic       IorD;
  logic       IRWrite;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       RegDst;
  logic       RegWrite;
  logic       MemToReg;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic [2:0] AluOp;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, MemRead, MemToWrite, IorD, IRWrite, PCWrite, PCSrc,
           RegDst, RegWrite, MemToReg, AluSrcA, AluSrcB, AluOp
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, MemRead, MemToWrite, IorD, IRWrite, PCWrite, PCSrc,
           RegDst, RegWrite, MemToReg, AluSrcA, AluSrcB, AluOp
  );
endinterface

// File: rtl/multicycle_control_fsm_op_class_decoder.sv
// Combinational opcode classifier; the immediate ALU operation is resolved here so the
// controller only has to latch three bits at DECODE.
module op_class_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  output op_class_t  cls
);
  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: cls.is_r = 1'b1;
      OP_LW: begin
        cls.is_mem = 1'b1;
        cls.is_lw  = 1'b1;
      end
      OP_SW:  cls.is_mem = 1'b1;
      OP_BEQ: cls.is_beq = 1'b1;
      OP_ADDI: begin
        cls.is_imm    = 1'b1;
        cls.imm_aluop = ALU_ADD;
      end
      OP_ANDI: begin
        cls.is_imm    = 1'b1;
        cls.imm_aluop = ALU_AND;
      end
      OP_ORI: begin
        cls.is_imm    = 1'b1;
        cls.imm_aluop = ALU_OR;
      end
      OP_J:    cls.is_j    = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS sequencing controller: Moore decode of the state register, with PC/IR
// writes qualified by the memory handshake in FETCH and by the zero flag in BRANCH.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter bit TRAP_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_fsm_if.master  ctrl,
  output logic                      illegal_op,
  output logic [STATE_W-1:0]        state_o
);
  state_t    state_reg, state_next;
  logic [2:0] imm_aluop_reg, imm_aluop_next;
  logic      lw_reg, lw_next;
  op_class_t cls;

  op_class_decoder u_dec (
    .op  (ctrl.op),
    .cls (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      imm_aluop_reg <= ALU_ADD;
      lw_reg        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      imm_aluop_reg <= imm_aluop_next;
      lw_reg        <= lw_next;
    end
  end

  // The opcode is only looked at in DECODE; later stages use the latched class bits.
  always_comb begin
    state_next     = state_reg;
    imm_aluop_next = imm_aluop_reg;
    lw_next        = lw_reg;
    case (state_reg)
      ST_IDLE:   state_next = ST_FETCH;
      ST_FETCH:  if (ctrl.mem_ready) state_next = ST_DECODE;
      ST_DECODE: begin
        imm_aluop_next = cls.imm_aluop;
        lw_next        = cls.is_lw;
        if (cls.is_r)                   state_next = ST_EXEC_R;
        else if (cls.is_mem)            state_next = ST_MEMADR;
        else if (cls.is_beq)            state_next = ST_BRANCH;
        else if (cls.is_imm)            state_next = ST_EXEC_I;
        else if (cls.is_j)              state_next = ST_JUMP;
        else if (cls.illegal && TRAP_EN) state_next = ST_TRAP;
        else                            state_next = ST_FETCH;
      end
      ST_EXEC_R: state_next = ST_WB_R;
      ST_WB_R:   state_next = ST_FETCH;
      ST_EXEC_I: state_next = ST_WB_I;
      ST_WB_I:   state_next = ST_FETCH;
      ST_MEMADR: state_next = lw_reg ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  if (ctrl.mem_ready) state_next = ST_MEMWB;
      ST_MEMWB:  state_next = ST_FETCH;
      ST_MEMWR:  if (ctrl.mem_ready) state_next = ST_FETCH;
      ST_BRANCH: state_next = ST_FETCH;
      ST_JUMP:   state_next = ST_FETCH;
      ST_TRAP:   state_next = ST_TRAP;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl.mem_req    = 1'b0;
    ctrl.MemRead    = 1'b0;
    ctrl.MemToWrite = 1'b0;
    ctrl.IorD       = 1'b0;
    ctrl.IRWrite    = 1'b0;
    ctrl.PCWrite    = 1'b0;
    ctrl.PCSrc      = PCSRC_ALU;
    ctrl.RegDst     = 1'b0;
    ctrl.RegWrite   = 1'b0;
    ctrl.MemToReg   = 1'b0;
    ctrl.AluSrcA    = 1'b0;
    ctrl.AluSrcB    = SRCB_REG;
    ctrl.AluOp      = ALU_ADD;
    case (state_reg)
      ST_FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.MemRead = 1'b1;
        ctrl.AluSrcB = SRCB_FOUR;
        ctrl.IRWrite = ctrl.mem_ready;
        ctrl.PCWrite = ctrl.mem_ready;
      end
      ST_DECODE: ctrl.AluSrcB = SRCB_IMM_SH2;
      ST_EXEC_R: begin
        ctrl.AluSrcA = 1'b1;
        ctrl.AluOp   = ALU_FUNCT;
      end
      ST_WB_R: begin
        ctrl.RegDst   = 1'b1;
        ctrl.RegWrite = 1'b1;
      end
      ST_EXEC_I: begin
        ctrl.AluSrcA = 1'b1;
        ctrl.AluSrcB = SRCB_IMM;
        ctrl.AluOp   = imm_aluop_reg;
      end
      ST_WB_I: ctrl.RegWrite = 1'b1;
      ST_MEMADR: begin
        ctrl.AluSrcA = 1'b1;
        ctrl.AluSrcB = SRCB_IMM;
      end
      ST_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.MemRead = 1'b1;
        ctrl.IorD    = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.RegWrite = 1'b1;
        ctrl.MemToReg = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_req    = 1'b1;
        ctrl.MemToWrite = 1'b1;
        ctrl.IorD       = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.AluSrcA = 1'b1;
        ctrl.AluOp   = ALU_SUB;
        ctrl.PCSrc   = PCSRC_ALUOUT;
        ctrl.PCWrite = ctrl.zero;
      end
      ST_JUMP: begin
        ctrl.PCSrc   = PCSRC_JUMP;
        ctrl.PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal_op = (state_reg == ST_TRAP);
  assign state_o    = STATE_W'(state_reg);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed cycle table, trap and no-trap sequences,
// then random instruction streams checked against a signal-by-signal reference model.
module tb_multicycle_control_fsm;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       mr;
    logic       z;
    state_t     st;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic       mw;
    logic [2:0] aop;
    logic       ill;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n0, rst_n1;
  logic [5:0] op;
  logic       zero, mem_ready;
  logic       ill0, ill1;
  logic [3:0] st0, st1;
  outs_t      act0, act1;
  int         checks = 0;
  int         errors = 0;

  multicycle_control_fsm_if b0 ();
  multicycle_control_fsm_if b1 ();

  assign b0.op = op;
  assign b0.zero = zero;
  assign b0.mem_ready = mem_ready;
  assign b1.op = op;
  assign b1.zero = zero;
  assign b1.mem_ready = mem_ready;

  assign act0 = {b0.mem_req, b0.MemRead, b0.MemToWrite, b0.IorD, b0.IRWrite, b0.PCWrite, b0.PCSrc,
                 b0.RegDst, b0.RegWrite, b0.MemToReg, b0.AluSrcA, b0.AluSrcB, b0.AluOp};
  assign act1 = {b1.mem_req, b1.MemRead, b1.MemToWrite, b1.IorD, b1.IRWrite, b1.PCWrite, b1.PCSrc,
                 b1.RegDst, b1.RegWrite, b1.MemToReg, b1.AluSrcA, b1.AluSrcB, b1.AluOp};

  multicycle_control_fsm #(.STATE_W(4), .TRAP_EN(1'b0)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n0),
    .ctrl       (b0),
    .illegal_op (ill0),
    .state_o    (st0)
  );

  multicycle_control_fsm #(.STATE_W(4), .TRAP_EN(1'b1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n1),
    .ctrl       (b1),
    .illegal_op (ill1),
    .state_o    (st1)
  );

  // Reference: each output written as the set of states (plus qualifying inputs) that assert it.
  function automatic outs_t model(input state_t s, input logic mr, input logic z, input logic [2:0] imm_op);
    outs_t o;
    o = '0;
    o.mem_req    = s inside {ST_FETCH, ST_MEMRD, ST_MEMWR};
    o.mem_read   = s inside {ST_FETCH, ST_MEMRD};
    o.mem_write  = (s == ST_MEMWR);
    o.iord       = s inside {ST_MEMRD, ST_MEMWR};
    o.ir_write   = (s == ST_FETCH) && mr;
    o.pc_write   = ((s == ST_FETCH) && mr) || ((s == ST_BRANCH) && z) || (s == ST_JUMP);
    o.pc_src     = (s == ST_BRANCH) ? 2'b01 : (s == ST_JUMP) ? 2'b10 : 2'b00;
    o.reg_dst    = (s == ST_WB_R);
    o.reg_write  = s inside {ST_WB_R, ST_WB_I, ST_MEMWB};
    o.mem_to_reg = (s == ST_MEMWB);
    o.alu_src_a  = s inside {ST_EXEC_R, ST_EXEC_I, ST_MEMADR, ST_BRANCH};
    o.alu_src_b  = (s == ST_FETCH) ? 2'b01 : (s == ST_DECODE) ? 2'b11 :
                   (s inside {ST_EXEC_I, ST_MEMADR}) ? 2'b10 : 2'b00;
    o.alu_op     = (s == ST_EXEC_R) ? 3'b010 : (s == ST_BRANCH) ? 3'b001 :
                   (s == ST_EXEC_I) ? imm_op : 3'b000;
    return o;
  endfunction

  function automatic logic [2:0] imm_of(input logic [5:0] o);
    if (o == 6'b001100) return 3'b011;
    if (o == 6'b001101) return 3'b100;
    return 3'b000;
  endfunction

  function automatic vec_t mk(input logic r, input logic [5:0] o, input logic mr, input logic z,
                              input state_t st, input logic irw, input logic pcw, input logic [1:0] pcs,
                              input logic rw, input logic rd, input logic m2r, input logic mw,
                              input logic [2:0] aop, input logic ill);
    vec_t v;
    v.rst = r; v.op = o; v.mr = mr; v.z = z; v.st = st; v.irw = irw; v.pcw = pcw; v.pcs = pcs;
    v.rw = rw; v.rd = rd; v.m2r = m2r; v.mw = mw; v.aop = aop; v.ill = ill;
    return v;
  endfunction

  task automatic cyc(input logic r0, input logic r1, input logic [5:0] o, input logic mr, input logic z);
    @(negedge clk);
    rst_n0 = r0;
    rst_n1 = r1;
    op = o;
    mem_ready = mr;
    zero = z;
    #1;
  endtask

  task automatic check_outs(input string tag, input int idx, input state_t es, input outs_t eo, input logic ei,
                            input logic [3:0] st_a, input outs_t ao, input logic ai);
    checks++;
    if (st_a !== es || ao !== eo || ai !== ei) begin
      errors++;
      $display("FAIL %s[%0d] got state=%0d outs=%05h ill=%b required state=%0d outs=%05h ill=%b",
               tag, idx, st_a, ao, ai, es, eo, ei);
    end
  endtask

  vec_t       tbl[$];
  state_t     path[$];
  logic [5:0] legal [8];
  logic [5:0] iop;
  logic [15:0] exp_key, act_key;
  logic       mr_r, z_r;
  int         ncyc, nwait;

  initial begin
    rst_n0 = 1'b0; rst_n1 = 1'b0; op = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    legal = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_J};

    // r, op, mr, z, state, irw, pcw, pcs, rw, rd, m2r, mw, aop, ill
    tbl.push_back(mk(0, 6'h00, 1, 0, ST_IDLE,   0,0,2'b00,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h00, 1, 0, ST_IDLE,   0,0,2'b00,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h00, 1, 0, ST_FETCH,  1,1,2'b00,0,0,0,0,3'b000,0)); // R-type
    tbl.push_back(mk(1, 6'h00, 1, 0, ST_DECODE, 0,0,2'b00,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h2b, 1, 0, ST_EXEC_R, 0,0,2'b00,0,0,0,0,3'b010,0));
    tbl.push_back(mk(1, 6'h2b, 1, 0, ST_WB_R,   0,0,2'b00,1,1,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h00, 1, 0, ST_FETCH,  1,1,2'b00,0,0,0,0,3'b000,0)); // lw with wait
    tbl.push_back(mk(1, 6'h23, 1, 0, ST_DECODE, 0,0,2'b00,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h00, 1, 0, ST_MEMADR, 0,0,2'b00,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h00, 0, 0, ST_MEMRD,  0,0,2'b00,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h00, 0, 0, ST_MEMRD,  0,0,2'b00,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h00, 1, 0, ST_MEMRD,  0,0,2'b00,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h00, 1, 0, ST_MEMWB,  0,0,2'b00,1,0,1,0,3'b000,0));
    tbl.push_back(mk(1, 6'h00, 1, 1, ST_FETCH,  1,1,2'b00,0,0,0,0,3'b000,0)); // beq taken
    tbl.push_back(mk(1, 6'h04, 1, 1, ST_DECODE, 0,0,2'b00,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h00, 1, 1, ST_BRANCH, 0,1,2'b01,0,0,0,0,3'b001,0));
    tbl.push_back(mk(1, 6'h00, 1, 0, ST_FETCH,  1,1,2'b00,0,0,0,0,3'b000,0)); // beq not taken
    tbl.push_back(mk(1, 6'h04, 1, 0, ST_DECODE, 0,0,2'b00,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h00, 1, 0, ST_BRANCH, 0,0,2'b01,0,0,0,0,3'b001,0));
    tbl.push_back(mk(1, 6'h00, 0, 0, ST_FETCH,  0,0,2'b00,0,0,0,0,3'b000,0)); // sw + fetch wait
    tbl.push_back(mk(1, 6'h00, 1, 0, ST_FETCH,  1,1,2'b00,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h2b, 1, 0, ST_DECODE, 0,0,2'b00,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h23, 0, 0, ST_MEMADR, 0,0,2'b00,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h23, 1, 0, ST_MEMWR,  0,0,2'b00,0,0,0,1,3'b000,0));
    tbl.push_back(mk(1, 6'h00, 1, 0, ST_FETCH,  1,1,2'b00,0,0,0,0,3'b000,0)); // reset mid-MEMWR
    tbl.push_back(mk(1, 6'h2b, 1, 0, ST_DECODE, 0,0,2'b00,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h00, 0, 0, ST_MEMADR, 0,0,2'b00,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h00, 0, 0, ST_MEMWR,  0,0,2'b00,0,0,0,1,3'b000,0));
    tbl.push_back(mk(0, 6'h00, 1, 0, ST_IDLE,   0,0,2'b00,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h00, 1, 0, ST_IDLE,   0,0,2'b00,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h00, 1, 0, ST_FETCH,  1,1,2'b00,0,0,0,0,3'b000,0)); // j
    tbl.push_back(mk(1, 6'h02, 1, 0, ST_DECODE, 0,0,2'b00,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h00, 1, 0, ST_JUMP,   0,1,2'b10,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h00, 1, 0, ST_FETCH,  1,1,2'b00,0,0,0,0,3'b000,0)); // andi, op changes later
    tbl.push_back(mk(1, 6'h0c, 1, 0, ST_DECODE, 0,0,2'b00,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h0d, 1, 0, ST_EXEC_I, 0,0,2'b00,0,0,0,0,3'b011,0));
    tbl.push_back(mk(1, 6'h0d, 1, 0, ST_WB_I,   0,0,2'b00,1,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h00, 1, 0, ST_FETCH,  1,1,2'b00,0,0,0,0,3'b000,0)); // illegal -> trap
    tbl.push_back(mk(1, 6'h3f, 1, 0, ST_DECODE, 0,0,2'b00,0,0,0,0,3'b000,0));
    tbl.push_back(mk(1, 6'h00, 1, 1, ST_TRAP,   0,0,2'b00,0,0,0,0,3'b000,1));

    foreach (tbl[i]) begin
      cyc(1'b0, tbl[i].rst, tbl[i].op, tbl[i].mr, tbl[i].z);
      exp_key = {4'(tbl[i].st), tbl[i].irw, tbl[i].pcw, tbl[i].pcs, tbl[i].rw, tbl[i].rd,
                 tbl[i].m2r, tbl[i].mw, tbl[i].aop, tbl[i].ill};
      act_key = {st1, act1.ir_write, act1.pc_write, act1.pc_src, act1.reg_write, act1.reg_dst,
                 act1.mem_to_reg, act1.mem_write, act1.alu_op, ill1};
      checks++;
      if (act_key !== exp_key) begin
        errors++;
        $display("FAIL table[%0d] got %04h required %04h", i, act_key, exp_key);
      end
      if (tbl[i].st inside {ST_IDLE, ST_TRAP}) begin
        checks++;
        if (act1 !== '0) begin
          errors++;
          $display("FAIL quiet[%0d] got outs=%05h required 00000", i, act1);
        end
      end
      $display("row %0d op=%02h mr=%b z=%b state=%0d", i, tbl[i].op, tbl[i].mr, tbl[i].z, st1);
    end

    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 6'($urandom), 1'($urandom), 1'($urandom));
      check_outs("trap", i, ST_TRAP, '0, 1'b1, st1, act1, ill1);
    end
    $display("trap held for 20 cycles");

    // No-trap variant: illegal opcode falls straight back to FETCH with no writes.
    cyc(1'b1, 1'b1, 6'h3f, 1'b1, 1'b0);
    check_outs("notrap", 0, ST_IDLE, '0, 1'b0, st0, act0, ill0);
    cyc(1'b1, 1'b1, 6'h3f, 1'b1, 1'b0);
    check_outs("notrap", 1, ST_FETCH, model(ST_FETCH, 1'b1, 1'b0, 3'b000), 1'b0, st0, act0, ill0);
    cyc(1'b1, 1'b1, 6'h3f, 1'b1, 1'b1);
    check_outs("notrap", 2, ST_DECODE, model(ST_DECODE, 1'b1, 1'b1, 3'b000), 1'b0, st0, act0, ill0);
    cyc(1'b1, 1'b1, 6'h3f, 1'b0, 1'b1);
    check_outs("notrap", 3, ST_FETCH, model(ST_FETCH, 1'b0, 1'b1, 3'b000), 1'b0, st0, act0, ill0);
    cyc(1'b1, 1'b1, 6'h00, 1'b1, 1'b0);
    check_outs("notrap", 4, ST_FETCH, model(ST_FETCH, 1'b1, 1'b0, 3'b000), 1'b0, st0, act0, ill0);
    cyc(1'b1, 1'b1, OP_J, 1'b1, 1'b0);
    check_outs("notrap", 5, ST_DECODE, model(ST_DECODE, 1'b1, 1'b0, 3'b000), 1'b0, st0, act0, ill0);
    cyc(1'b1, 1'b1, 6'h3f, 1'b1, 1'b0);
    check_outs("notrap", 6, ST_JUMP, model(ST_JUMP, 1'b1, 1'b0, 3'b000), 1'b0, st0, act0, ill0);
    $display("no-trap illegal opcode sequence done");

    cyc(1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
    check_outs("rreset", 0, ST_IDLE, '0, 1'b0, st1, act1, ill1);
    cyc(1'b0, 1'b1, 6'h00, 1'b1, 1'b0);
    check_outs("rreset", 1, ST_IDLE, '0, 1'b0, st1, act1, ill1);

    for (int n = 0; n < 200; n++) begin
      iop = legal[$urandom_range(0, 7)];
      path.delete();
      path.push_back(ST_FETCH);
      path.push_back(ST_DECODE);
      case (iop)
        OP_RTYPE: begin path.push_back(ST_EXEC_R); path.push_back(ST_WB_R); end
        OP_LW:    begin path.push_back(ST_MEMADR); path.push_back(ST_MEMRD); path.push_back(ST_MEMWB); end
        OP_SW:    begin path.push_back(ST_MEMADR); path.push_back(ST_MEMWR); end
        OP_BEQ:   path.push_back(ST_BRANCH);
        OP_J:     path.push_back(ST_JUMP);
        default:  begin path.push_back(ST_EXEC_I); path.push_back(ST_WB_I); end
      endcase
      ncyc = 0;
      nwait = 0;
      foreach (path[k]) begin
        do begin
          if (path[k] inside {ST_FETCH, ST_MEMRD, ST_MEMWR})
            mr_r = ($urandom_range(0, 99) < 65);
          else
            mr_r = 1'($urandom);
          z_r = 1'($urandom);
          cyc(1'b0, 1'b1, (path[k] == ST_DECODE) ? iop : 6'($urandom), mr_r, z_r);
          check_outs("rand", n, path[k], model(path[k], mr_r, z_r, imm_of(iop)), 1'b0, st1, act1, ill1);
          ncyc++;
          if ((path[k] inside {ST_FETCH, ST_MEMRD, ST_MEMWR}) && !mr_r) nwait++;
        end while ((path[k] inside {ST_FETCH, ST_MEMRD, ST_MEMWR}) && !mr_r);
      end
      $display("instr %0d op=%02h cycles=%0d base=%0d waits=%0d", n, iop, ncyc, path.size(), nwait);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
